// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the responder FSM state encoding.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WCAP  = 3'd1,
        ST_WBRAM = 3'd2,
        ST_WRESP = 3'd3,
        ST_RBRAM = 3'd4,
        ST_RWAIT = 3'd5,
        ST_RRESP = 3'd6
    } state_t;

endpackage

// File: rtl/axi_lite_bram_responder.sv
// AXI4-Lite slave bridging single-word reads/writes onto BRAM port A.
// One transaction in flight at a time; read/write collisions alternate priority.
module axi_lite_bram_responder
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int BRAM_AW  = 10,
    parameter int BRAM_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [ADDR_W-1:0]     s_awaddr,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [DATA_W-1:0]     s_wdata,
    input  logic [DATA_W/8-1:0]   s_wstrb,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    input  logic [ADDR_W-1:0]     s_araddr,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [DATA_W-1:0]     s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic                  bram_clk,
    output logic                  bram_rst,
    output logic                  bram_en,
    output logic [DATA_W/8-1:0]   bram_we,
    output logic [BRAM_AW-1:0]    bram_addr,
    output logic [DATA_W-1:0]     bram_din,
    input  logic [DATA_W-1:0]     bram_dout
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(BRAM_LAT) + 1;

    state_t              state_reg;
    state_t              state_next;
    logic                last_wr_reg;
    logic                aw_done_reg;
    logic                w_done_reg;
    logic [BRAM_AW-1:0]  waddr_reg;
    logic                decerr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [STRB_W-1:0]   wstrb_reg;
    logic [1:0]          bresp_reg;
    logic [DATA_W-1:0]   rdata_reg;
    logic [1:0]          rresp_reg;
    logic [CNT_W-1:0]    lat_cnt_reg;
    logic                bram_rst_reg;

    logic wr_req;
    logic rd_go;
    logic wr_go;
    logic aw_hs;
    logic w_hs;
    logic aw_have;
    logic w_have;

    // Byte-address bits [1:0] select a byte lane only; word access ignores them.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_awaddr[1:0], s_araddr[1:0]};

    // Any set bit above the BRAM word range is a decode error; no aliasing.
    function automatic logic out_of_range(input logic [ADDR_W-1:0] addr);
        return (addr >> (BRAM_AW + 2)) != '0;
    endfunction

    assign wr_req  = s_awvalid | s_wvalid;
    assign rd_go   = (state_reg == ST_IDLE) && s_arvalid && (!wr_req || last_wr_reg);
    assign wr_go   = (state_reg == ST_IDLE) && wr_req && !rd_go;
    assign aw_hs   = s_awvalid && s_awready;
    assign w_hs    = s_wvalid && s_wready;
    assign aw_have = aw_done_reg || aw_hs;
    assign w_have  = w_done_reg || w_hs;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (rd_go) begin
                    state_next = ST_RBRAM;
                end else if (wr_go) begin
                    state_next = ST_WCAP;
                end
            end
            ST_WCAP: begin
                if (aw_have && w_have) begin
                    state_next = ST_WBRAM;
                end
            end
            ST_WBRAM: state_next = ST_WRESP;
            ST_WRESP: begin
                if (s_bready) begin
                    state_next = ST_IDLE;
                end
            end
            ST_RBRAM: state_next = ST_RWAIT;
            ST_RWAIT: begin
                if (lat_cnt_reg == '0) begin
                    state_next = ST_RRESP;
                end
            end
            ST_RRESP: begin
                if (s_rready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        s_awready = 1'b0;
        s_wready  = 1'b0;
        s_arready = 1'b0;
        s_bvalid  = 1'b0;
        s_rvalid  = 1'b0;
        bram_en   = 1'b0;
        bram_we   = '0;
        unique case (state_reg)
            ST_IDLE:  s_arready = rd_go;
            ST_WCAP: begin
                s_awready = !aw_done_reg;
                s_wready  = !w_done_reg;
            end
            ST_WBRAM: begin
                bram_en = !decerr_reg;
                bram_we = decerr_reg ? '0 : wstrb_reg;
            end
            ST_WRESP: s_bvalid = 1'b1;
            ST_RBRAM: bram_en  = !decerr_reg;
            ST_RWAIT: ;
            ST_RRESP: s_rvalid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_wr_reg <= 1'b0;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            waddr_reg   <= '0;
            decerr_reg  <= 1'b0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
            bresp_reg   <= RESP_OKAY;
            rdata_reg   <= '0;
            rresp_reg   <= RESP_OKAY;
            lat_cnt_reg <= '0;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (rd_go) begin
                        last_wr_reg <= 1'b0;
                        waddr_reg   <= s_araddr[BRAM_AW+1:2];
                        decerr_reg  <= out_of_range(s_araddr);
                    end else if (wr_go) begin
                        last_wr_reg <= 1'b1;
                        aw_done_reg <= 1'b0;
                        w_done_reg  <= 1'b0;
                    end
                end
                ST_WCAP: begin
                    if (aw_hs) begin
                        aw_done_reg <= 1'b1;
                        waddr_reg   <= s_awaddr[BRAM_AW+1:2];
                        decerr_reg  <= out_of_range(s_awaddr);
                    end
                    if (w_hs) begin
                        w_done_reg <= 1'b1;
                        wdata_reg  <= s_wdata;
                        wstrb_reg  <= s_wstrb;
                    end
                end
                ST_WBRAM: bresp_reg <= decerr_reg ? RESP_DECERR : RESP_OKAY;
                ST_RBRAM: lat_cnt_reg <= CNT_W'(BRAM_LAT - 1);
                ST_RWAIT: begin
                    if (lat_cnt_reg == '0) begin
                        rdata_reg <= decerr_reg ? '0 : bram_dout;
                        rresp_reg <= decerr_reg ? RESP_DECERR : RESP_OKAY;
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Held in reset one extra cycle so the BRAM sees a clean edge after rstn rises.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bram_rst_reg <= 1'b1;
        end else begin
            bram_rst_reg <= 1'b0;
        end
    end

    assign bram_clk  = clk;
    assign bram_rst  = bram_rst_reg;
    assign bram_addr = waddr_reg;
    assign bram_din  = wdata_reg;
    assign s_bresp   = bresp_reg;
    assign s_rdata   = rdata_reg;
    assign s_rresp   = rresp_reg;

endmodule
